// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: byte-wide cpu port, 4-byte block memory port.
// Optional hit/miss counters are built in when DCACHE_STATS_EN is defined.
module dcache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int NB    = 1 << INDEX_BITS;
  localparam int TAG_W = 6 - INDEX_BITS;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FETCH     = 2'd2;
  localparam logic [1:0] UPDATE    = 2'd3;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [31:0]           data [NB];
  logic [TAG_W-1:0]      tags [NB];
  logic [NB-1:0]         valid;
  logic [NB-1:0]         dirty;
  logic [31:0]           fill_buf;

  logic [TAG_W-1:0]      addr_tag;
  logic [INDEX_BITS-1:0] idx;
  logic [1:0]            offset;
  logic                  req;
  logic                  hit;
  logic                  write_hit;

  assign addr_tag  = address[7 -: TAG_W];
  assign idx       = address[2 +: INDEX_BITS];
  assign offset    = address[1:0];
  assign req       = read | write;
  assign hit       = valid[idx] && (tags[idx] == addr_tag);
  // write wins when read and write are both high
  assign write_hit = (state == IDLE) && write && hit;

  assign busywait = req && !((state == IDLE) && hit);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (req && !hit) next_state = dirty[idx] ? WRITEBACK : FETCH;
      WRITEBACK: if (!mem_busywait) next_state = FETCH;
      FETCH:     if (!mem_busywait) next_state = UPDATE;
      UPDATE:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      fill_buf <= '0;
    end else begin
      state <= next_state;
      if ((state == FETCH) && !mem_busywait) fill_buf <= mem_readdata;
      if (state == UPDATE) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (write_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Data and tags need no reset: valid gates every use of them.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data[idx] <= fill_buf;
      tags[idx] <= addr_tag;
    end else if (write_hit) begin
      data[idx][{offset, 3'b000} +: 8] <= writedata;
    end
  end

  always_comb begin
    mem_read      = (state == FETCH);
    mem_write     = (state == WRITEBACK);
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      WRITEBACK: begin
        mem_address   = {tags[idx], idx};
        mem_writedata = data[idx];
      end
      FETCH:   mem_address = {addr_tag, idx};
      default: mem_address = '0;
    endcase
  end

  assign readdata = RESET ? 8'h00 : data[idx][{offset, 3'b000} +: 8];

`ifdef DCACHE_STATS_EN
  logic replay;

  // replay marks the post-refill completion so it is not counted as a hit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
      replay     <= 1'b0;
    end else begin
      if (state == UPDATE) replay <= 1'b1;
      else if (state == IDLE) replay <= 1'b0;
      if ((state == IDLE) && req && hit && !replay && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'd1;
      if ((state == IDLE) && req && !hit && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end
`else
  // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller against a block memory with 5 busy cycles per request.
module tb_dcache_controller;
  localparam int L = 5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dcache_controller dut (
    .CLK(CLK), .RESET(RESET), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory: untouched blocks hold byte value = byte address; written blocks are overlaid.
  function automatic logic [31:0] init_block(input logic [5:0] b);
    logic [7:0] a;
    a = {b, 2'b00};
    return {a + 8'd3, a + 8'd2, a + 8'd1, a};
  endfunction

  logic        mem_clr;
  logic [31:0] wr_dat [64];
  logic [63:0] wr_vld;
  int          lat_cnt;

  assign mem_busywait = (mem_read | mem_write) && (lat_cnt != L);
  assign mem_readdata = wr_vld[mem_address] ? wr_dat[mem_address] : init_block(mem_address);

  always @(posedge CLK or posedge mem_clr) begin
    if (mem_clr) begin
      wr_vld  <= '0;
      lat_cnt <= 0;
    end else if (mem_read | mem_write) begin
      if (lat_cnt == L) begin
        lat_cnt <= 0;
        if (mem_write) begin
          wr_dat[mem_address] <= mem_writedata;
          wr_vld[mem_address] <= 1'b1;
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  logic        saw_rd, saw_wr;
  logic [5:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  int          rd_cyc, wr_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge and returns once busywait is low (1 ns after a negedge).
  // busy = number of cycles busywait was high, including the miss-detection cycle.
  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, output int busy);
    busy   = 0;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    read = rd; write = wr; address = addr; writedata = wd;
    #1;
    while (busywait && busy < 200) begin
      if (mem_read && !saw_rd) begin
        saw_rd = 1'b1; rd_addr = mem_address; rd_cyc = busy;
      end
      if (mem_write && !saw_wr) begin
        saw_wr = 1'b1; wr_addr = mem_address; wr_data = mem_writedata; wr_cyc = busy;
      end
      busy++;
      @(negedge CLK);
      #1;
    end
  endtask

  // Holds the request across one posedge (completion), then drops it.
  task automatic release_req();
    @(negedge CLK);
    read = 1'b0;
    write = 1'b0;
  endtask

  int busy;

  initial begin
    RESET = 1'b1; mem_clr = 1'b1;
    read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
    #2 mem_clr = 1'b0;

    @(negedge CLK); #1;
    check("rst_busywait_idle", 32'(busywait), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_writedata", mem_writedata, 32'd0);
    check("rst_readdata", 32'(readdata), 32'd0);
    read = 1'b1; address = 8'h2A; #1;
    check("rst_busywait_req", 32'(busywait), 32'd1);
    read = 1'b0;
`ifdef DCACHE_STATS_EN
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
`endif
    @(negedge CLK); RESET = 1'b0;

    // Cold miss: 0x2A -> tag 1, index 2, block 0x0A. Stall = FETCH (L+1) + UPDATE.
    access(1'b1, 1'b0, 8'h2A, 8'h00, busy);
    check("cold_stall", 32'(busy - 1), 32'(L + 2));
    check("cold_mem_read_seen", 32'(saw_rd), 32'd1);
    check("cold_mem_address", 32'(rd_addr), 32'h0A);
    check("cold_no_writeback", 32'(saw_wr), 32'd0);
    check("cold_readdata", 32'(readdata), 32'h2A);
    release_req();

    access(1'b1, 1'b0, 8'h2B, 8'h00, busy);
    check("hit_2B_busy", 32'(busy), 32'd0);
    check("hit_2B_readdata", 32'(readdata), 32'h2B);
    release_req();

    access(1'b0, 1'b1, 8'h2A, 8'hEE, busy);
    check("wr_hit_busy", 32'(busy), 32'd0);
    check("wr_hit_no_mem", 32'(mem_read | mem_write), 32'd0);
    release_req();
    check("wr_hit_dirty2", 32'(dut.dirty[2]), 32'd1);

    access(1'b1, 1'b0, 8'h2A, 8'h00, busy);
    check("rd_after_wr_busy", 32'(busy), 32'd0);
    check("rd_after_wr_data", 32'(readdata), 32'hEE);
    release_req();

    // Dirty eviction: victim block 0x0A = bytes {2B, EE, 29, 28}, refill block 0x12.
    access(1'b1, 1'b0, 8'h4A, 8'h00, busy);
    check("evict_stall", 32'(busy - 1), 32'(2 * L + 3));
    check("evict_wb_seen", 32'(saw_wr), 32'd1);
    check("evict_wb_address", 32'(wr_addr), 32'h0A);
    check("evict_wb_data", wr_data, 32'h2BEE2928);
    check("evict_fetch_address", 32'(rd_addr), 32'h12);
    check("evict_order", 32'(wr_cyc < rd_cyc), 32'd1);
    check("evict_readdata", 32'(readdata), 32'h4A);
    release_req();

    // Back-to-back hits in consecutive cycles.
    access(1'b1, 1'b0, 8'h48, 8'h00, busy);
    check("b2b_48_busy", 32'(busy), 32'd0);
    check("b2b_48_data", 32'(readdata), 32'h48);
    release_req();
    access(1'b1, 1'b0, 8'h49, 8'h00, busy);
    check("b2b_49_busy", 32'(busy), 32'd0);
    check("b2b_49_data", 32'(readdata), 32'h49);
    release_req();

    // read and write together behave as a write.
    access(1'b1, 1'b1, 8'h4B, 8'h77, busy);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_no_mem", 32'(mem_read | mem_write), 32'd0);
    release_req();
    check("rw_dirty2", 32'(dut.dirty[2]), 32'd1);
    access(1'b1, 1'b0, 8'h4B, 8'h00, busy);
    check("rw_readback", 32'(readdata), 32'h77);
    release_req();

`ifdef DCACHE_STATS_EN
    // Hits: 2B, wr 2A, rd 2A, 48, 49, rw 4B, rd 4B. Misses: 2A, 4A.
    check("stats_hit_count", 32'(hit_count), 32'd7);
    check("stats_miss_count", 32'(miss_count), 32'd2);
`endif

    // Async reset two cycles into a refill of 0x0C (index 3, invalid).
    read = 1'b1; address = 8'h0C;
    @(negedge CLK); #1;
    check("fetch_mem_read", 32'(mem_read), 32'd1);
    check("fetch_mem_address", 32'(mem_address), 32'h03);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("midrst_mem_read", 32'(mem_read), 32'd0);
    check("midrst_mem_address", 32'(mem_address), 32'd0);
    check("midrst_readdata", 32'(readdata), 32'd0);
    check("midrst_busywait", 32'(busywait), 32'd1);
    read = 1'b0;
    @(negedge CLK); RESET = 1'b0;

    access(1'b1, 1'b0, 8'h0C, 8'h00, busy);
    check("rerd_stall", 32'(busy - 1), 32'(L + 2));
    check("rerd_fetch_address", 32'(rd_addr), 32'h03);
    check("rerd_readdata", 32'(readdata), 32'h0C);
    release_req();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
